// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, immediate mux
// and ALU control decode behind a valid/ready handshake with stall and flush.
module id_ex_stage #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic [XLEN-1:0]    imm,
    input  logic               alu_src,
    input  logic [1:0]         alu_class,
    input  logic [2:0]         funct3,
    input  logic               funct7_5,
    input  logic [RADDR_W-1:0] rd,
    input  logic               reg_write,
    input  logic [1:0]         fwd_a,
    input  logic [1:0]         fwd_b,
    input  logic [XLEN-1:0]    fwd_mem_data,
    input  logic [XLEN-1:0]    fwd_wb_data,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_in1,
    output logic [XLEN-1:0]    alu_in2,
    output logic [3:0]         alu_ctrl,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_reg_write,
    output logic               illegal_op
);
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic            load;
    logic [XLEN-1:0] op_a, op_b, rs2_fwd;
    logic [3:0]      ctrl;
    logic            ill;

    assign in_ready = !stall && (!out_valid || out_ready);
    assign load     = in_valid && in_ready;

    always_comb begin
        op_a    = fwd_a == 2'b01 ? fwd_mem_data : fwd_a == 2'b10 ? fwd_wb_data : rs1_data;
        rs2_fwd = fwd_b == 2'b01 ? fwd_mem_data : fwd_b == 2'b10 ? fwd_wb_data : rs2_data;
        op_b    = alu_src ? imm : rs2_fwd;
        ill     = alu_class[1] && !(funct3 inside {3'b000, 3'b111, 3'b110, 3'b010});
        // funct7[5] selects SUB only for R-type; I-type ADDI ignores it
        ctrl    = !alu_class[1]     ? (alu_class[0] ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b111 ? ALU_AND :
                  funct3 == 3'b110 ? ALU_OR  :
                  funct3 == 3'b010 ? ALU_SLT :
                  (funct3 == 3'b000 && !alu_class[0] && funct7_5) ? ALU_SUB : ALU_ADD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            alu_in1       <= '0;
            alu_in2       <= '0;
            alu_ctrl      <= ALU_ADD;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            illegal_op    <= 1'b0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                out_valid     <= 1'b1;
                alu_in1       <= op_a;
                alu_in2       <= op_b;
                alu_ctrl      <= ctrl;
                out_rd        <= rd;
                out_reg_write <= reg_write && !ill;
                illegal_op    <= ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; expected outputs are queued
// at acceptance and compared while the stage presents them.
module tb_id_ex_stage;
    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  c;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    logic        clk = 0, reset = 0, in_valid = 0, in_ready;
    logic [63:0] rs1_data = 0, rs2_data = 0, imm = 0, fwd_mem_data = 0, fwd_wb_data = 0;
    logic        alu_src = 0, funct7_5 = 0, reg_write = 0, stall = 0, flush = 0, out_ready = 0;
    logic [1:0]  alu_class = 0, fwd_a = 0, fwd_b = 0;
    logic [2:0]  funct3 = 0;
    logic [4:0]  rd = 0, out_rd;
    logic        out_valid, out_reg_write, illegal_op;
    logic [63:0] alu_in1, alu_in2;
    logic [3:0]  alu_ctrl;

    exp_t q[$];
    exp_t got;
    logic mv = 0;
    int   checks = 0, fails = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
        .alu_class(alu_class), .funct3(funct3), .funct7_5(funct7_5), .rd(rd),
        .reg_write(reg_write), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data), .stall(stall),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;
    assign got = '{alu_in1, alu_in2, alu_ctrl, out_rd, out_reg_write, illegal_op};

    function automatic exp_t model();
        exp_t e;
        logic [63:0] r2;
        e.a = fwd_a == 2'd1 ? fwd_mem_data : fwd_a == 2'd2 ? fwd_wb_data : rs1_data;
        r2  = fwd_b == 2'd1 ? fwd_mem_data : fwd_b == 2'd2 ? fwd_wb_data : rs2_data;
        e.b = alu_src ? imm : r2;
        e.ill = 0;
        case (alu_class)
            2'b00: e.c = 4'b0010;
            2'b01: e.c = 4'b0110;
            default: case (funct3)
                3'b000: e.c = (alu_class == 2'b10 && funct7_5) ? 4'b0110 : 4'b0010;
                3'b111: e.c = 4'b0000;
                3'b110: e.c = 4'b0001;
                3'b010: e.c = 4'b0111;
                default: begin e.c = 4'b0010; e.ill = 1; end
            endcase
        endcase
        e.rd = rd;
        e.rw = reg_write && !e.ill;
        return e;
    endfunction

    // advance one cycle, updating the model's valid bit and scoreboard
    task automatic tick();
        bit   ld, dr;
        exp_t e;
        e  = model();
        ld = in_valid && !stall && (!mv || out_ready) && !flush && !reset;
        dr = mv && out_ready && !stall && !flush && !reset;
        @(posedge clk);
        if (reset || flush) begin
            mv = 0;
            q.delete();
        end else begin
            if (dr && q.size() > 0) void'(q.pop_front());
            if (ld) q.push_back(e);
            mv = ld ? 1'b1 : dr ? 1'b0 : mv;
        end
        #1;
    endtask

    task automatic set_in(logic [1:0] cls, logic [2:0] f3, logic f7, logic [63:0] a, logic [63:0] b);
        in_valid = 1; alu_class = cls; funct3 = f3; funct7_5 = f7;
        rs1_data = a; rs2_data = b; rd = 5'($urandom); reg_write = 1;
        alu_src = 0; fwd_a = 0; fwd_b = 0;
    endtask

    task automatic test_reset();
        set_in(2'b10, 3'b000, 1, 64'd99, 64'd1);
        reset = 1;
        tick(); tick();
        reset = 0; in_valid = 0;
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++;
        if (got !== exp_t'({64'd0, 64'd0, 4'b0010, 5'd0, 1'b0, 1'b0}))
            begin fails++; $display("FAIL reset_regs got %h exp ctrl=0010 rest 0", got); end
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_rtype_sub();
        out_ready = 1;
        set_in(2'b10, 3'b000, 1, 64'd10, 64'd3);
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL sub_valid got %b exp 1", out_valid); end
        checks++;
        if (got !== q[0] || alu_ctrl !== 4'b0110 || alu_in1 !== 64'd10 || alu_in2 !== 64'd3)
            begin fails++; $display("FAIL sub_data got %h exp %h", got, q[0]); end
        tick();
    endtask

    task automatic test_fwd_imm();
        set_in(2'b11, 3'b010, 0, 64'd7, 64'd8);
        fwd_a = 2'b01; fwd_mem_data = '1; alu_src = 1; imm = 64'd5;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || got !== q[0] || alu_in1 !== '1 || alu_in2 !== 64'd5 || alu_ctrl !== 4'b0111)
            begin fails++; $display("FAIL fwd_imm got v=%b %h exp %h", out_valid, got, q[0]); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        set_in(2'b10, 3'b110, 0, 64'h1234, 64'h5678);
        tick();
        set_in(2'b10, 3'b111, 0, 64'hAAAA, 64'hBBBB);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== q[0])
                begin fails++; $display("FAIL bp_hold%0d rdy=%b v=%b got %h exp %h", i, in_ready, out_valid, got, q[0]); end
        end
        in_valid = 0; out_ready = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_stall_flush();
        exp_t snap;
        set_in(2'b00, 3'b000, 0, 64'd1, 64'd2);
        tick();
        in_valid = 0; stall = 1; flush = 1;
        tick();
        flush = 0;
        checks++;
        if (out_valid !== 1'b0 || out_reg_write !== 1'b0)
            begin fails++; $display("FAIL stall_flush v=%b rw=%b exp 0 0", out_valid, out_reg_write); end
        stall = 0;
        set_in(2'b01, 3'b000, 0, 64'd40, 64'd2);
        fwd_b = 2'b10; fwd_wb_data = 64'hC0FFEE;
        tick();
        snap = q[0];
        stall = 1; out_ready = 1;
        set_in(2'b10, 3'b111, 0, 64'd9, 64'd9);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== snap)
                begin fails++; $display("FAIL stall_hold%0d v=%b rdy=%b got %h exp %h", i, out_valid, in_ready, got, snap); end
        end
        stall = 0; in_valid = 0;
        tick();
    endtask

    task automatic test_illegal();
        set_in(2'b10, 3'b001, 0, 64'd5, 64'd6);
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || illegal_op !== 1'b1 || out_reg_write !== 1'b0 || alu_ctrl !== 4'b0010 || got !== q[0])
            begin fails++; $display("FAIL illegal got v=%b %h exp %h", out_valid, got, q[0]); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            set_in(2'($urandom), 3'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            in_valid = 1'($urandom_range(0, 3) != 0);
            fwd_a = 2'($urandom); fwd_b = 2'($urandom); alu_src = 1'($urandom);
            reg_write = 1'($urandom);
            imm = {$urandom, $urandom}; fwd_mem_data = {$urandom, $urandom}; fwd_wb_data = {$urandom, $urandom};
            out_ready = 1'($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (out_valid !== mv || in_ready !== (!stall && (!mv || out_ready)))
                begin fails++; $display("FAIL b2b_hs%0d v=%b exp %b rdy=%b", i, out_valid, mv, in_ready); end
            if (mv) begin
                checks++;
                if (got !== q[0]) begin fails++; $display("FAIL b2b_data%0d got %h exp %h", i, got, q[0]); end
            end
        end
        in_valid = 0; stall = 0; flush = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_rtype_sub();
        test_fwd_imm();
        test_backpressure();
        test_stall_flush();
        test_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
